// File: rtl/mtm_test_sequencer_fsm_if.sv
// Sequencer <-> chopper bundle: descriptor copy, enable and phase
// out, command write strobe and last-command flag back in.
interface mtm_test_sequencer_fsm_if;
    logic        chop_enable;
    logic [63:0] chop_base_address;
    logic [31:0] chop_transfer_length;
    logic [23:0] chop_block_size;
    logic        chop_read_phase;
    logic        chop_fifo_write;
    logic        chop_fifo_last_command;

    modport master (
        output chop_enable,
        output chop_base_address,
        output chop_transfer_length,
        output chop_block_size,
        output chop_read_phase,
        input  chop_fifo_write,
        input  chop_fifo_last_command
    );

    modport slave (
        input  chop_enable,
        input  chop_base_address,
        input  chop_transfer_length,
        input  chop_block_size,
        input  chop_read_phase,
        output chop_fifo_write,
        output chop_fifo_last_command
    );
endinterface

// File: rtl/mtm_test_sequencer_fsm.sv
// Memory tester sequencer: runs write/read pass loops through the chopper.
// Ports: clk/reset, go/stop + desc_*, chop bundle (master), master done
// pulses, compare_error; status busy/done/error flags and counters.
module mtm_test_sequencer_fsm #(
    parameter int LOOP_WIDTH    = 16,
    parameter int STOP_ON_ERROR = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic                  stop,
    input  logic [63:0]           desc_base_address,
    input  logic [31:0]           desc_transfer_length,
    input  logic [23:0]           desc_block_size,
    input  logic [LOOP_WIDTH-1:0] desc_loop_count,
    mtm_test_sequencer_fsm_if.master chop,
    input  logic                  write_master_done,
    input  logic                  read_master_done,
    input  logic                  compare_error,
    output logic                  busy,
    output logic                  done,
    output logic                  error_seen,
    output logic                  config_error,
    output logic [LOOP_WIDTH-1:0] loops_completed,
    output logic [31:0]           commands_issued
);

    typedef enum logic [2:0] {
        IDLE, LOAD, WR_ISSUE, WR_DRAIN,
        RD_ISSUE, RD_DRAIN, LOOP_CHK, DONE
    } state_t;

    state_t                state;
    logic [LOOP_WIDTH-1:0] loop_count;
    logic                  stop_pending;
    logic                  wr_pend;
    logic                  rd_pend;
    logic                  last_cmd;
    logic                  loop_end;

    assign last_cmd = chop.chop_fifo_write & chop.chop_fifo_last_command;

    // Compare one bit wider so the all-ones loop count still terminates.
    assign loop_end = (loop_count != '0) &&
        (({1'b0, loops_completed} + (LOOP_WIDTH+1)'(1)) ==
         {1'b0, loop_count});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                     <= IDLE;
            loop_count                <= '0;
            stop_pending              <= 1'b0;
            wr_pend                   <= 1'b0;
            rd_pend                   <= 1'b0;
            chop.chop_enable          <= 1'b0;
            chop.chop_base_address    <= '0;
            chop.chop_transfer_length <= '0;
            chop.chop_block_size      <= '0;
            chop.chop_read_phase      <= 1'b0;
            busy                      <= 1'b0;
            done                      <= 1'b0;
            error_seen                <= 1'b0;
            config_error              <= 1'b0;
            loops_completed           <= '0;
            commands_issued           <= '0;
        end else begin
            // Sticky bookkeeping; the go-accept clears below override it.
            if (busy && chop.chop_fifo_write)
                commands_issued <= commands_issued + 32'd1;
            if (busy && compare_error)
                error_seen <= 1'b1;
            if (busy && stop)
                stop_pending <= 1'b1;
            // A master may retire before the chopper flags its last command.
            if (state == WR_ISSUE && write_master_done)
                wr_pend <= 1'b1;
            if (state == RD_ISSUE && read_master_done)
                rd_pend <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (go) begin
                        chop.chop_base_address    <= desc_base_address;
                        chop.chop_transfer_length <= desc_transfer_length;
                        chop.chop_block_size      <= desc_block_size;
                        loop_count                <= desc_loop_count;
                        commands_issued           <= '0;
                        loops_completed           <= '0;
                        error_seen                <= 1'b0;
                        config_error              <= 1'b0;
                        stop_pending              <= 1'b0;
                        wr_pend                   <= 1'b0;
                        rd_pend                   <= 1'b0;
                        busy                      <= 1'b1;
                        state                     <= LOAD;
                    end
                end
                LOAD: begin
                    if (chop.chop_transfer_length == '0 ||
                        chop.chop_block_size == '0) begin
                        config_error <= 1'b1;
                        done         <= 1'b1;
                        state        <= DONE;
                    end else begin
                        chop.chop_read_phase <= 1'b0;
                        chop.chop_enable     <= 1'b1;
                        state                <= WR_ISSUE;
                    end
                end
                WR_ISSUE: begin
                    if (last_cmd) begin
                        chop.chop_enable <= 1'b0;
                        state            <= WR_DRAIN;
                    end
                end
                WR_DRAIN: begin
                    // Enable has been low for at least this cycle.
                    if (write_master_done || wr_pend) begin
                        wr_pend              <= 1'b0;
                        chop.chop_read_phase <= 1'b1;
                        chop.chop_enable     <= 1'b1;
                        state                <= RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    if (last_cmd) begin
                        chop.chop_enable <= 1'b0;
                        state            <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    if (read_master_done || rd_pend) begin
                        rd_pend              <= 1'b0;
                        chop.chop_read_phase <= 1'b0;
                        state                <= LOOP_CHK;
                    end
                end
                LOOP_CHK: begin
                    if (loops_completed != '1)
                        loops_completed <= loops_completed + LOOP_WIDTH'(1);
                    if (stop_pending || loop_end ||
                        ((STOP_ON_ERROR != 0) && error_seen)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        chop.chop_enable <= 1'b1;
                        state            <= WR_ISSUE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mtm_test_sequencer_fsm.sv
// Scoreboard bench for mtm_test_sequencer_fsm with a behavioural chopper
// and write/read master model driving the command and done handshakes.
module tb_mtm_test_sequencer_fsm;

    typedef struct {
        logic        phase;
        logic [63:0] base;
        logic [31:0] len;
        logic [23:0] bs;
    } pass_t;

    typedef struct {
        logic [15:0] loops;
        logic [31:0] cmds;
        logic        err;
        logic        cfg;
    } res_t;

    logic        clk;
    logic        reset;
    logic        go;
    logic        stop;
    logic [63:0] desc_base_address;
    logic [31:0] desc_transfer_length;
    logic [23:0] desc_block_size;
    logic [15:0] desc_loop_count;
    logic        write_master_done;
    logic        read_master_done;
    logic        compare_error;
    logic        busy;
    logic        done;
    logic        error_seen;
    logic        config_error;
    logic [15:0] loops_completed;
    logic [31:0] commands_issued;

    mtm_test_sequencer_fsm_if bus ();

    mtm_test_sequencer_fsm #(
        .LOOP_WIDTH    (16),
        .STOP_ON_ERROR (1)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .go                   (go),
        .stop                 (stop),
        .desc_base_address    (desc_base_address),
        .desc_transfer_length (desc_transfer_length),
        .desc_block_size      (desc_block_size),
        .desc_loop_count      (desc_loop_count),
        .chop                 (bus),
        .write_master_done    (write_master_done),
        .read_master_done     (read_master_done),
        .compare_error        (compare_error),
        .busy                 (busy),
        .done                 (done),
        .error_seen           (error_seen),
        .config_error         (config_error),
        .loops_completed      (loops_completed),
        .commands_issued      (commands_issued)
    );

    int    tests;
    int    fails;
    int    done_cnt;
    int    wr_pass;
    int    stop_pass;
    int    err_pass;
    logic  hold_read;
    logic  prev_en;
    pass_t pq[$];
    res_t  rq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT opens a pass or ends a test.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.chop_enable && !prev_en) begin
                if (pq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pass: got phase %0b expected none",
                             bus.chop_read_phase);
                end else begin
                    pass_t p;
                    p = pq.pop_front();
                    chk("pass_phase", 64'(bus.chop_read_phase), 64'(p.phase));
                    chk("pass_base", bus.chop_base_address, p.base);
                    chk("pass_len", 64'(bus.chop_transfer_length), 64'(p.len));
                    chk("pass_bs", 64'(bus.chop_block_size), 64'(p.bs));
                end
            end
            if (done) begin
                done_cnt++;
                if (rq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done expected none");
                end else begin
                    res_t r;
                    r = rq.pop_front();
                    chk("done_loops", 64'(loops_completed), 64'(r.loops));
                    chk("done_cmds", 64'(commands_issued), 64'(r.cmds));
                    chk("done_err", 64'(error_seen), 64'(r.err));
                    chk("done_cfg", 64'(config_error), 64'(r.cfg));
                    chk("done_busy", 64'(busy), 64'd1);
                end
            end
        end
        prev_en = bus.chop_enable;
    end

    // Chopper + master model: issues ceil(len/bs) commands per pass,
    // then retires the pass a few cycles after the last command.
    initial begin
        int n;
        logic ph;
        bus.chop_fifo_write        = 1'b0;
        bus.chop_fifo_last_command = 1'b0;
        write_master_done          = 1'b0;
        read_master_done           = 1'b0;
        compare_error              = 1'b0;
        stop                       = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.chop_enable && !reset &&
                !(hold_read && bus.chop_read_phase)) begin
                ph = bus.chop_read_phase;
                if (!ph) wr_pass++;
                n = int'((bus.chop_transfer_length +
                          32'(bus.chop_block_size) - 32'd1) /
                         32'(bus.chop_block_size));
                for (int i = 0; i < n; i++) begin
                    bus.chop_fifo_write        = 1'b1;
                    bus.chop_fifo_last_command = (i == n - 1);
                    stop = !ph && (wr_pass == stop_pass) && (i == 0);
                    @(posedge clk);
                    #1;
                end
                bus.chop_fifo_write        = 1'b0;
                bus.chop_fifo_last_command = 1'b0;
                stop                       = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    compare_error = ph && (wr_pass == err_pass) && (k == 1);
                    @(posedge clk);
                    #1;
                end
                compare_error = 1'b0;
                if (ph) read_master_done = 1'b1;
                else    write_master_done = 1'b1;
                @(posedge clk);
                #1;
                read_master_done  = 1'b0;
                write_master_done = 1'b0;
            end
        end
    end

    task automatic push_passes(input int loops, input logic [63:0] base,
                               input logic [31:0] len, input logic [23:0] bs);
        for (int l = 0; l < loops; l++) begin
            pq.push_back('{1'b0, base, len, bs});
            pq.push_back('{1'b1, base, len, bs});
        end
    endtask

    task automatic start(input logic [63:0] base, input logic [31:0] len,
                         input logic [23:0] bs, input logic [15:0] cnt);
        @(posedge clk);
        #1;
        desc_base_address    = base;
        desc_transfer_length = len;
        desc_block_size      = bs;
        desc_loop_count      = cnt;
        wr_pass              = 0;
        go                   = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int c0;
        bit seen;
        c0   = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done_cnt != c0) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done expected done", name);
        end
        repeat (2) @(negedge clk);
        chk({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bit seen;
        tests                = 0;
        fails                = 0;
        done_cnt             = 0;
        wr_pass              = 0;
        stop_pass            = 0;
        err_pass             = 0;
        hold_read            = 1'b0;
        prev_en              = 1'b0;
        reset                = 1'b1;
        go                   = 1'b0;
        desc_base_address    = '0;
        desc_transfer_length = '0;
        desc_block_size      = '0;
        desc_loop_count      = '0;

        repeat (3) @(negedge clk);
        chk("rst_enable", 64'(bus.chop_enable), 64'd0);
        chk("rst_phase", 64'(bus.chop_read_phase), 64'd0);
        chk("rst_base", bus.chop_base_address, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(error_seen), 64'd0);
        chk("rst_cfg", 64'(config_error), 64'd0);
        chk("rst_loops", 64'(loops_completed), 64'd0);
        chk("rst_cmds", 64'(commands_issued), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single loop: 4 write + 4 read commands.
        push_passes(1, 64'h1234_5678_0000_1000, 32'h400, 24'h100);
        rq.push_back('{16'd1, 32'd8, 1'b0, 1'b0});
        start(64'h1234_5678_0000_1000, 32'h400, 24'h100, 16'd1);
        wait_done("one_loop", 400);

        // Three loops, 2 commands per pass (0x300/0x200 rounds up).
        push_passes(3, 64'h0000_0000_8000_0000, 32'h300, 24'h200);
        rq.push_back('{16'd3, 32'd12, 1'b0, 1'b0});
        start(64'h0000_0000_8000_0000, 32'h300, 24'h200, 16'd3);
        wait_done("three_loops", 600);

        // Endless run stopped during loop 2 write issue.
        stop_pass = 2;
        push_passes(2, 64'hAAAA_0000_0000_0040, 32'h100, 24'h100);
        rq.push_back('{16'd2, 32'd4, 1'b0, 1'b0});
        start(64'hAAAA_0000_0000_0040, 32'h100, 24'h100, 16'd0);
        wait_done("stop_run", 600);
        stop_pass = 0;

        // Miscompare in loop 1 read drain ends a 5-loop test early.
        err_pass = 1;
        push_passes(1, 64'h0000_0001_0000_0000, 32'h200, 24'h100);
        rq.push_back('{16'd1, 32'd4, 1'b1, 1'b0});
        start(64'h0000_0001_0000_0000, 32'h200, 24'h100, 16'd5);
        wait_done("error_stop", 600);
        err_pass = 0;

        // Zero length: config error, done 2 cycles after go, go held busy.
        rq.push_back('{16'd0, 32'd0, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        desc_transfer_length = 32'h0;
        desc_block_size      = 24'h100;
        desc_loop_count      = 16'd1;
        go                   = 1'b1;
        @(posedge clk);
        #1;
        chk("cfg_busy", 64'(busy), 64'd1);
        chk("cfg_no_done_yet", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        chk("cfg_done_latency", 64'(done), 64'd1);
        go = 1'b0;
        repeat (12) @(negedge clk);
        chk("cfg_idle", 64'(busy), 64'd0);
        chk("cfg_single_done", 64'(done_cnt), 64'd5);

        // Reset while the read pass is issuing.
        hold_read = 1'b1;
        push_passes(1, 64'h0000_0000_0000_2000, 32'h200, 24'h100);
        start(64'h0000_0000_0000_2000, 32'h200, 24'h100, 16'd1);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.chop_enable && bus.chop_read_phase) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL rd_issue_timeout: got no read pass expected one");
        end
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_enable", 64'(bus.chop_enable), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_cmds", 64'(commands_issued), 64'd0);
        chk("mid_rst_loops", 64'(loops_completed), 64'd0);
        @(negedge clk);
        chk("mid_rst_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        hold_read = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_no_done", 64'(done_cnt), 64'd5);

        chk("pass_queue_empty", 64'(pq.size()), 64'd0);
        chk("done_queue_empty", 64'(rq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
